cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Sits between the icache/dcache controllers and the single line-wide physical-memory port.
//  Accepts icache line reads and dcache line reads/writebacks, serializes them, and routes pmem_rdata/pmem_resp back to the owner.
//  Runs one transaction at a time.
//  Adds one cycle of issue latency and zero cycles of return latency.
// PARAMETERS
//  ADDR_W    32   address width, byte address of the line
//  LINE_W    256  cache line width in bits
//  RR_MODE   1    1 = round-robin on tie; 0 = fixed dcache priority
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-LOW reset (rst==0 at posedge resets)
//  i_pmem_read    in   1       icache line read request; held until i_pmem_resp
//  i_pmem_address in   ADDR_W  icache line address
//  i_pmem_rdata   out  LINE_W  line data to icache
//  i_pmem_resp    out  1       icache transaction complete (1-cycle pulse)
//  d_pmem_read    in   1       dcache line read request; held until d_pmem_resp
//  d_pmem_write   in   1       dcache writeback request; held until d_pmem_resp
//  d_pmem_address in   ADDR_W  dcache line address
//  d_pmem_wdata   in   LINE_W  dcache writeback data
//  d_pmem_rdata   out  LINE_W  line data to dcache
//  d_pmem_resp    out  1       dcache transaction complete (1-cycle pulse)
//  pmem_read      out  1       memory read strobe, level, held until pmem_resp
//  pmem_write     out  1       memory write strobe, level, held until pmem_resp
//  pmem_address   out  ADDR_W  memory address
//  pmem_wdata     out  LINE_W  memory write data
//  pmem_rdata     in   LINE_W  memory read data, valid with pmem_resp
//  pmem_resp      in   1       memory transaction complete
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, last_grant=ICACHE, captured addr/wdata/op = 0
//   - every output 0, except i_/d_pmem_rdata, which follow pmem_rdata (don't-care while resp=0)
//  FSM states: IDLE, SERVE_I, SERVE_D, DONE.
//  IDLE, request selection:
//   - icache only: capture i_pmem_address into the request register; go to SERVE_I.
//   - dcache only: capture address, wdata and op; go to SERVE_D.
//   - both, RR_MODE=1: grant the side not equal to last_grant.
//   - both, RR_MODE=0: dcache always wins.
//  IDLE, outputs: no pmem strobe is driven (issue latency is 1 cycle).
//  SERVE_x:
//   - Drive pmem_read/pmem_write, pmem_address and pmem_wdata from the captured registers only; they are stable for the whole transaction.
//   - On pmem_resp, assert x_pmem_resp in the same cycle (combinational), set last_grant=x, and go to DONE.
//   - Without pmem_resp, stay in SERVE_x.
//  DONE:
//   - One idle cycle with no strobes and no resp.
//   - Lets the requester drop its request before it is re-sampled; then go to IDLE.
//   - Minimum spacing between two pmem transactions is 2 cycles.
//  rdata: pmem_rdata is broadcast to both i_pmem_rdata and d_pmem_rdata; only the owner's resp pulses.
//  Op encoding:
//   - d_pmem_write has precedence over d_pmem_read when both are high (illegal input).
//   - The captured op is fixed until DONE.
//  Input changes mid-transaction:
//   - Address or request changes by either requester after grant are ignored.
//   - Withdrawal mid-transaction: the memory transaction still runs to pmem_resp, and the resp pulse is still issued.
//  Non-owner: the non-owner's resp is never asserted; its pending request waits in place with no timeout.
//  pmem_resp outside SERVE_x is ignored.
//  Reset mid-transaction:
//   - Return to IDLE immediately and drop all strobes the following cycle.
//   - The memory side is reset together with the arbiter.
//  Single-port guarantee: never both pmem_read and pmem_write; never both i_ and d_ resp in the same cycle.
// STRUCTURE
//  Package cache_arb_pkg:
//   - arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}
//   - owner_t enum {ICACHE, DCACHE}
//   - arb_op_t enum {OP_READ, OP_WRITE}
//   - localparam LINE_W_DEF=256
//  Sub-module arb_req_reg: load-enabled capture register for {op, address, wdata}, with synchronous active-low clear.
//  The FSM, grant select and output muxing stay in cache_arbiter.
// TESTING
//  1. icache read, addr 0x0000_1000, memory resp after 5 cycles:
//     - pmem_read rises 1 cycle after i_pmem_read, with pmem_address 0x1000.
//     - i_pmem_resp pulses with rdata = memory line; d_pmem_resp stays 0.
//  2. dcache writeback, addr 0x0000_2040, wdata pattern 0xA5..A5:
//     - pmem_write=1, pmem_read=0, pmem_wdata matches, held until resp.
//     - d_pmem_resp is 1 cycle long.
//  3. Both request in the same cycle from reset, RR_MODE=1, then both re-request:
//     - Grant order: D (0x3000), then I (0x4000), then D.
//     - With RR_MODE=0: D every time a tie occurs.
//  4. Memory responds on the first SERVE cycle:
//     - resp in the same cycle; the DONE gap is 1 cycle.
//     - A held request is not re-issued until IDLE; a new request starts 2 cycles after the previous resp.
//  5. dcache changes address 0x5000 -> 0x6000 mid-SERVE_D:
//     - pmem_address stays 0x5000.
//     - d_pmem_read and d_pmem_write both high -> the write is issued.
//  6. rst driven 0 while in SERVE_I with pmem_read=1:
//     - Next cycle all strobes and resps are 0 and state=IDLE.
//     - After release, a pending dcache request is granted first.
//  Continuous assertions: never pmem_read&&pmem_write; never i_pmem_resp&&d_pmem_resp; pmem_address constant during SERVE_x.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache-to-memory arbiter: FSM states, transaction owner and captured op.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } owner_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

endpackage

// File: rtl/arb_req_reg.sv
// Capture register for the granted request; holds op/address/wdata stable for a whole transaction.
module arb_req_reg
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  arb_op_t           op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output arb_op_t           op_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LINE_W-1:0] wdata_o
);

    arb_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load_i) begin
            op_q    <= op_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign op_o    = op_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/cache_arbiter.sv
// Serializes icache reads and dcache reads/writebacks onto one line-wide memory port,
// one transaction at a time, and routes the memory response back to the owning cache.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter bit RR_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    owner_t            last_grant_q, last_grant_d;
    owner_t            grant;
    logic              i_req, d_req, serving;
    logic              load;
    arb_op_t           cap_op_d, op_q;
    logic [ADDR_W-1:0] cap_addr_d, addr_q;
    logic [LINE_W-1:0] cap_wdata_d, wdata_q;

    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    // On a tie, round-robin hands the grant to whoever was not served last.
    always_comb begin
        grant = ICACHE;
        if (d_req && (!i_req || !RR_MODE || (last_grant_q == ICACHE))) begin
            grant = DCACHE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= ICACHE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        cap_op_d     = OP_READ;
        cap_addr_d   = i_pmem_address;
        cap_wdata_d  = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    load = 1'b1;
                    if (grant == DCACHE) begin
                        cap_op_d    = d_pmem_write ? OP_WRITE : OP_READ;
                        cap_addr_d  = d_pmem_address;
                        cap_wdata_d = d_pmem_wdata;
                        state_d     = SERVE_D;
                    end else begin
                        state_d = SERVE_I;
                    end
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_pmem_resp  = 1'b1;
                    last_grant_d = ICACHE;
                    state_d      = DONE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_pmem_resp  = 1'b1;
                    last_grant_d = DCACHE;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    arb_req_reg #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .op_i    (cap_op_d),
        .addr_i  (cap_addr_d),
        .wdata_i (cap_wdata_d),
        .op_o    (op_q),
        .addr_o  (addr_q),
        .wdata_o (wdata_q)
    );

    // Memory-side signals come only from the capture register, so requester changes cannot leak through.
    assign pmem_read    = serving && (op_q == OP_READ);
    assign pmem_write   = serving && (op_q == OP_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: a round-robin and a fixed-priority instance share requester inputs,
// each with its own memory responder, checked every cycle against a transaction-level model.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    typedef logic [LW-1:0] line_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_pmem_read;
    logic [AW-1:0]   i_pmem_address;
    logic            d_pmem_read;
    logic            d_pmem_write;
    logic [AW-1:0]   d_pmem_address;
    line_t           d_pmem_wdata;
    logic            pr [2];
    logic            pw [2];
    logic            ir [2];
    logic            dr [2];
    logic            presp [2];
    logic [AW-1:0]   pa [2];
    line_t           pwd [2];
    line_t           prd [2];
    line_t           ird [2];
    line_t           drd [2];

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = none, 1 = icache, 2 = dcache
    int            m_own [2];
    int            m_gap [2];
    int            m_last [2];
    logic          m_wr [2];
    logic [AW-1:0] m_addr [2];
    line_t         m_wd [2];
    int            mem_cnt [2];
    int            mem_lat [2];
    bit            prev_strobe [2];
    bit            spurious;
    bit            i_got, d_got;
    int            cyc;
    logic [AW-1:0] iss0 [$];
    logic [AW-1:0] iss1 [$];
    int            ist0 [$];

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(ird[0]), .i_pmem_resp(ir[0]),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(drd[0]), .d_pmem_resp(dr[0]),
        .pmem_read(pr[0]), .pmem_write(pw[0]), .pmem_address(pa[0]),
        .pmem_wdata(pwd[0]), .pmem_rdata(prd[0]), .pmem_resp(presp[0])
    );

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_MODE(1'b0)) dut_fx (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(ird[1]), .i_pmem_resp(ir[1]),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(drd[1]), .d_pmem_resp(dr[1]),
        .pmem_read(pr[1]), .pmem_write(pw[1]), .pmem_address(pa[1]),
        .pmem_wdata(pwd[1]), .pmem_rdata(prd[1]), .pmem_resp(presp[1])
    );

    task automatic chk(input string tag, input line_t obs, input line_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    // Drive memory responses, compare both DUTs against the model, then advance the model one clock.
    task automatic evalc();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                presp[k]   = 1'b0;
                mem_cnt[k] = 0;
            end else if (pr[k] || pw[k]) begin
                if (mem_cnt[k] >= mem_lat[k]) begin
                    presp[k]   = 1'b1;
                    mem_cnt[k] = 0;
                    if (spurious) mem_lat[k] = $urandom_range(0, 4);
                end else begin
                    presp[k] = 1'b0;
                    mem_cnt[k]++;
                end
            end else begin
                presp[k]   = spurious && ($urandom_range(0, 3) == 0);
                mem_cnt[k] = 0;
            end
            prd[k] = rand_line();
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            string s;
            logic  e_rd, e_wr;
            s    = (k == 0) ? "rr" : "fx";
            e_rd = (m_own[k] != 0) && !m_wr[k];
            e_wr = (m_own[k] != 0) && m_wr[k];
            chk({s, ".pmem_read"}, line_t'(pr[k]), line_t'(e_rd));
            chk({s, ".pmem_write"}, line_t'(pw[k]), line_t'(e_wr));
            if (m_own[k] != 0) chk({s, ".pmem_address"}, line_t'(pa[k]), line_t'(m_addr[k]));
            if (e_wr) chk({s, ".pmem_wdata"}, pwd[k], m_wd[k]);
            chk({s, ".i_resp"}, line_t'(ir[k]), line_t'((m_own[k] == 1) && presp[k]));
            chk({s, ".d_resp"}, line_t'(dr[k]), line_t'((m_own[k] == 2) && presp[k]));
            chk({s, ".i_rdata"}, ird[k], prd[k]);
            chk({s, ".d_rdata"}, drd[k], prd[k]);
            chk({s, ".rw_excl"}, line_t'(pr[k] && pw[k]), line_t'(0));
            chk({s, ".resp_excl"}, line_t'(ir[k] && dr[k]), line_t'(0));
            if ((pr[k] || pw[k]) && !prev_strobe[k]) begin
                if (k == 0) begin
                    iss0.push_back(pa[k]);
                    ist0.push_back(cyc);
                end else begin
                    iss1.push_back(pa[k]);
                end
            end
            prev_strobe[k] = pr[k] || pw[k];
        end
        i_got = ir[0];
        d_got = dr[0];
        cyc++;
        for (int k = 0; k < 2; k++) begin
            bit ireq, dreq;
            int win;
            ireq = i_pmem_read;
            dreq = d_pmem_read || d_pmem_write;
            if (!rst) begin
                m_own[k]  = 0;
                m_gap[k]  = 0;
                m_last[k] = 1;
                m_wr[k]   = 1'b0;
            end else if (m_own[k] != 0) begin
                if (presp[k]) begin
                    m_last[k] = m_own[k];
                    m_own[k]  = 0;
                    m_gap[k]  = 1;
                end
            end else if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else begin
                win = 0;
                if (ireq && dreq) win = (k == 1) ? 2 : ((m_last[k] == 1) ? 2 : 1);
                else if (dreq)    win = 2;
                else if (ireq)    win = 1;
                m_own[k] = win;
                if (win == 1) begin
                    m_addr[k] = i_pmem_address;
                    m_wr[k]   = 1'b0;
                end else if (win == 2) begin
                    m_addr[k] = d_pmem_address;
                    m_wr[k]   = d_pmem_write;
                    m_wd[k]   = d_pmem_wdata;
                end
            end
        end
    endtask

    task automatic step();
        nxt();
        evalc();
    endtask

    task automatic wait_resp(input int side, input int budget, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            step();
            n++;
            got = (side == 1) ? i_got : d_got;
        end
        chk("resp_within_budget", line_t'(got), line_t'(1));
    endtask

    initial begin
        int n;
        bit i_act, d_act;
        rst = 1'b0; i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        spurious = 1'b0; cyc = 0; i_got = 1'b0; d_got = 1'b0;
        for (int k = 0; k < 2; k++) begin
            presp[k] = 1'b0; prd[k] = '0; m_own[k] = 0; m_gap[k] = 0; m_last[k] = 1;
            m_wr[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0; mem_cnt[k] = 0; mem_lat[k] = 1;
            prev_strobe[k] = 1'b0;
        end

        // Reset state
        step();
        step();
        chk("reset.addr_rr", line_t'(pa[0]), line_t'(0));
        chk("reset.wdata_rr", pwd[0], line_t'(0));
        chk("reset.addr_fx", line_t'(pa[1]), line_t'(0));

        // icache read, 5-cycle memory latency
        nxt(); rst = 1'b1; i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000; mem_lat = '{4, 4}; evalc();
        chk("t1.issue_latency", line_t'(pr[0]), line_t'(0));
        step();
        chk("t1.read_issued", line_t'(pr[0]), line_t'(1));
        chk("t1.address", line_t'(pa[0]), line_t'(32'h1000));
        wait_resp(1, 20, n);
        chk("t1.resp_cycles", line_t'(n), line_t'(4));
        chk("t1.rdata", ird[0], prd[0]);
        chk("t1.no_d_resp", line_t'(dr[0]), line_t'(0));
        nxt(); i_pmem_read = 1'b0; evalc();
        chk("t1.resp_pulse", line_t'(ir[0]), line_t'(0));
        step();

        // dcache writeback
        nxt(); d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040; d_pmem_wdata = {32{8'hA5}}; mem_lat = '{2, 2}; evalc();
        wait_resp(2, 20, n);
        chk("t2.resp_cycles", line_t'(n), line_t'(3));
        chk("t2.write_held", line_t'(pw[0]), line_t'(1));
        chk("t2.no_read", line_t'(pr[0]), line_t'(0));
        chk("t2.wdata", pwd[0], {32{8'hA5}});
        nxt(); d_pmem_write = 1'b0; evalc();
        chk("t2.resp_one_cycle", line_t'(dr[0]), line_t'(0));
        step();

        // Tie from reset: round-robin D,I,D versus fixed D,D,D
        nxt(); rst = 1'b0; evalc();
        nxt(); rst = 1'b1; iss0.delete(); iss1.delete();
        i_pmem_read = 1'b1; i_pmem_address = 32'h4000; d_pmem_read = 1'b1; d_pmem_address = 32'h3000;
        mem_lat = '{1, 1}; evalc();
        repeat (13) step();
        chk("t3.rr_count", line_t'(iss0.size() >= 3), line_t'(1));
        chk("t3.fx_count", line_t'(iss1.size() >= 3), line_t'(1));
        if (iss0.size() >= 3) begin
            chk("t3.rr_grant0", line_t'(iss0[0]), line_t'(32'h3000));
            chk("t3.rr_grant1", line_t'(iss0[1]), line_t'(32'h4000));
            chk("t3.rr_grant2", line_t'(iss0[2]), line_t'(32'h3000));
        end
        if (iss1.size() >= 3) begin
            chk("t3.fx_grant0", line_t'(iss1[0]), line_t'(32'h3000));
            chk("t3.fx_grant1", line_t'(iss1[1]), line_t'(32'h3000));
            chk("t3.fx_grant2", line_t'(iss1[2]), line_t'(32'h3000));
        end
        nxt(); i_pmem_read = 1'b0; d_pmem_read = 1'b0; evalc();
        repeat (4) step();

        // Zero-latency memory with a held request: issue every 3 cycles
        nxt(); ist0.delete(); i_pmem_read = 1'b1; i_pmem_address = 32'h7000; mem_lat = '{0, 0}; evalc();
        repeat (10) step();
        chk("t4.count", line_t'(ist0.size() >= 3), line_t'(1));
        if (ist0.size() >= 3) begin
            chk("t4.spacing1", line_t'(ist0[1] - ist0[0]), line_t'(3));
            chk("t4.spacing2", line_t'(ist0[2] - ist0[1]), line_t'(3));
        end
        nxt(); i_pmem_read = 1'b0; evalc();
        repeat (3) step();

        // Mid-transaction address/op change is ignored; read+write issues a write
        nxt(); d_pmem_read = 1'b1; d_pmem_address = 32'h5000; mem_lat = '{3, 3}; evalc();
        step();
        chk("t5.addr", line_t'(pa[0]), line_t'(32'h5000));
        nxt(); d_pmem_address = 32'h6000; d_pmem_write = 1'b1; evalc();
        chk("t5.addr_hold", line_t'(pa[0]), line_t'(32'h5000));
        chk("t5.op_hold", line_t'(pw[0]), line_t'(0));
        wait_resp(2, 20, n);
        nxt(); d_pmem_read = 1'b0; d_pmem_write = 1'b0; evalc();
        step();
        nxt(); d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h6000; evalc();
        step();
        chk("t5.both_write", line_t'(pw[0]), line_t'(1));
        chk("t5.both_no_read", line_t'(pr[0]), line_t'(0));
        wait_resp(2, 20, n);
        nxt(); d_pmem_read = 1'b0; d_pmem_write = 1'b0; evalc();
        step();

        // Reset during SERVE_I with a dcache request pending
        nxt(); i_pmem_read = 1'b1; i_pmem_address = 32'h8000; mem_lat = '{10, 10}; evalc();
        nxt(); d_pmem_read = 1'b1; d_pmem_address = 32'h9000; evalc();
        chk("t6.serving_i", line_t'(pr[0]), line_t'(1));
        nxt(); rst = 1'b0; evalc();
        nxt(); rst = 1'b1; iss0.delete(); evalc();
        chk("t6.read_dropped", line_t'(pr[0]), line_t'(0));
        chk("t6.write_low", line_t'(pw[0]), line_t'(0));
        chk("t6.i_resp_low", line_t'(ir[0]), line_t'(0));
        wait_resp(2, 30, n);
        chk("t6.granted", line_t'(iss0.size() >= 1), line_t'(1));
        if (iss0.size() >= 1) chk("t6.d_first", line_t'(iss0[0]), line_t'(32'h9000));
        nxt(); d_pmem_read = 1'b0; evalc();
        wait_resp(1, 30, n);
        nxt(); i_pmem_read = 1'b0; evalc();
        step();

        // Randomized traffic with spurious responses and occasional resets
        spurious = 1'b1; i_act = 1'b0; d_act = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            nxt();
            rst = ($urandom_range(0, 299) != 0);
            if (i_act) begin
                if (i_got) begin
                    i_pmem_read = 1'b0;
                    i_act = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    i_pmem_address = $urandom() & 32'hFFFF_FFE0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                i_pmem_read = 1'b1;
                i_act = 1'b1;
                i_pmem_address = $urandom() & 32'hFFFF_FFE0;
            end
            if (d_act) begin
                if (d_got) begin
                    d_pmem_read = 1'b0;
                    d_pmem_write = 1'b0;
                    d_act = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    d_pmem_address = $urandom() & 32'hFFFF_FFE0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                d_act = 1'b1;
                d_pmem_write = ($urandom_range(0, 1) == 1);
                d_pmem_read = !d_pmem_write || ($urandom_range(0, 15) == 0);
                d_pmem_address = $urandom() & 32'hFFFF_FFE0;
                d_pmem_wdata = rand_line();
            end
            evalc();
        end
        nxt(); i_pmem_read = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0; rst = 1'b1; evalc();
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
